// File: rtl/mario_sprite_render.sv
// mario_sprite_render: hit-tests the current VGA pixel against Mario's 16x16
// sprite, forms the sprite ROM address and produces the pipelined palette
// index. Latency is 3 frame_clk edges from DrawX/DrawY to mario_on/mario_idx.
//
// Ports:
//   frame_clk, Reset        pixel clock, asynchronous active-high reset
//   vs                      VGA vertical sync (active-low)
//   DrawX, DrawY            current pixel coordinate
//   MarioX, MarioY          sprite anchor: columns MarioX-16..MarioX-1,
//                           rows MarioY..MarioY+15
//   reverse, in_air,        facing-left / airborne / walking flags
//   walking
//   walking_frame           animation phase, bits [4:3] pick the walk pose
//   rom_addr                registered sprite ROM address (pose,row,col)
//   rom_data                synchronous ROM data, valid one cycle after rom_addr
//   mario_on, mario_idx     opaque-pixel flag and its palette index
//   pose                    pose of the last hit pixel: 0 idle, 1-3 walk, 4 jump
//
// Build option: define MARIO_SHADOW_EN to latch the motion inputs into shadow
// registers on each vs falling edge, so a frame renders from one snapshot.
module mario_sprite_render (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        vs,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  MarioX,
  input  logic [9:0]  MarioY,
  input  logic        reverse,
  input  logic        in_air,
  input  logic        walking,
  input  logic [4:0]  walking_frame,
  output logic [10:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        mario_on,
  output logic [3:0]  mario_idx,
  output logic [2:0]  pose
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 11;

  logic          vs_prev;
  logic          vs_fall;
  logic [CW-1:0] eff_x;
  logic [CW-1:0] eff_y;
  logic          eff_rev;
  logic          eff_air;
  logic          eff_walk;
  logic [1:0]    eff_wf;

  assign vs_fall = vs_prev & ~vs;

  // vs edge detector
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) vs_prev <= 1'b0;
    else       vs_prev <= vs;
  end

`ifdef MARIO_SHADOW_EN
  logic [CW-1:0] sh_x;
  logic [CW-1:0] sh_y;
  logic          sh_rev;
  logic          sh_air;
  logic          sh_walk;
  logic [1:0]    sh_wf;

  // Per-frame snapshot of the motion inputs
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      sh_x    <= '0;
      sh_y    <= '0;
      sh_rev  <= 1'b0;
      sh_air  <= 1'b0;
      sh_walk <= 1'b0;
      sh_wf   <= '0;
    end else if (vs_fall) begin
      sh_x    <= MarioX;
      sh_y    <= MarioY;
      sh_rev  <= reverse;
      sh_air  <= in_air;
      sh_walk <= walking;
      sh_wf   <= walking_frame[4:3];
    end
  end

  assign eff_x    = sh_x;
  assign eff_y    = sh_y;
  assign eff_rev  = sh_rev;
  assign eff_air  = sh_air;
  assign eff_walk = sh_walk;
  assign eff_wf   = sh_wf;
`else
  assign eff_x    = MarioX;
  assign eff_y    = MarioY;
  assign eff_rev  = reverse;
  assign eff_air  = in_air;
  assign eff_walk = walking;
  assign eff_wf   = walking_frame[4:3];
`endif

  // Only the top two phase bits matter; vs_fall is idle without shadowing
  logic unused_bits;
  assign unused_bits = ^{walking_frame[2:0], vs_fall};

  logic [2:0] pose_c;

  // Jump outranks walking; walk phase saturates at pose 3
  always_comb begin
    pose_c = 3'd0;
    if (eff_air) begin
      pose_c = 3'd4;
    end else if (eff_walk) begin
      case (eff_wf)
        2'd0:    pose_c = 3'd1;
        2'd1:    pose_c = 3'd2;
        default: pose_c = 3'd3;
      endcase
    end
  end

  // Signed compare so MarioX<16 clips at the left edge instead of wrapping
  logic signed [AW-1:0] dx_s;
  logic signed [AW-1:0] mx_s;
  logic signed [AW-1:0] left_s;
  logic                 in_x;
  logic                 in_y;
  logic                 on_screen;
  logic                 hit_c;
  logic [3:0]           col_raw;
  logic [3:0]           col;
  logic [3:0]           row;
  logic [AW-1:0]        addr_c;

  assign dx_s      = $signed({1'b0, DrawX});
  assign mx_s      = $signed({1'b0, eff_x});
  assign left_s    = mx_s - 11'sd16;
  assign in_x      = (dx_s >= left_s) && (dx_s < mx_s);
  assign in_y      = (DrawY >= eff_y) && ({1'b0, DrawY} < ({1'b0, eff_y} + 11'd16));
  assign on_screen = (DrawX < 10'd640) && (DrawY < 10'd480);
  assign hit_c     = in_x && in_y && on_screen;
  assign col_raw   = 4'(dx_s - left_s);
  assign col       = eff_rev ? ~col_raw : col_raw;   // 15-c
  assign row       = 4'(DrawY - eff_y);
  assign addr_c    = {pose_c, row, col};             // pose*256 + r*16 + c

  logic hit_d1;
  logic hit_d2;

  // Address stage, ROM-read stage, output stage
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      pose      <= '0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      mario_on  <= 1'b0;
      mario_idx <= '0;
    end else begin
      hit_d1 <= hit_c;
      if (hit_c) begin
        rom_addr <= addr_c;
        pose     <= pose_c;
      end
      hit_d2 <= hit_d1;
      if (hit_d2 && (rom_data != 4'd0)) begin
        mario_on  <= 1'b1;
        mario_idx <= rom_data;
      end else begin
        mario_on  <= 1'b0;
        mario_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mario_sprite_render.sv
// tb_mario_sprite_render: directed and randomized checks of mario_sprite_render
// against a behavioural model built from the sprite geometry rules, with a
// synchronous ROM model feeding rom_data.
module tb_mario_sprite_render;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        vs;
  logic [9:0]  DrawX, DrawY, MarioX, MarioY;
  logic        reverse, in_air, walking;
  logic [4:0]  walking_frame;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic        mario_on;
  logic [3:0]  mario_idx;
  logic [2:0]  pose;

  int n_tests = 0;
  int n_fail  = 0;

  mario_sprite_render dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .vs            (vs),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .MarioX        (MarioX),
    .MarioY        (MarioY),
    .reverse       (reverse),
    .in_air        (in_air),
    .walking       (walking),
    .walking_frame (walking_frame),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .mario_on      (mario_on),
    .mario_idx     (mario_idx),
    .pose          (pose)
  );

  always #5 frame_clk = ~frame_clk;

  // Sprite ROM contents: some entries are transparent (index 0)
  function automatic int rom_fn(input int a);
    return (a * 5 + 7) % 16;
  endfunction

  always_ff @(posedge frame_clk) rom_data <= 4'(rom_fn(int'(rom_addr)));

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_addr, m_pose, m_on, m_idx;
  int m_h1, m_a1, m_h2, m_a2;
  int m_vs_prev;
  int s_x, s_y, s_rev, s_air, s_walk, s_wf;

  task automatic model_reset();
    m_addr = 0; m_pose = 0; m_on = 0; m_idx = 0;
    m_h1 = 0; m_a1 = 0; m_h2 = 0; m_a2 = 0;
    m_vs_prev = 0;
    s_x = 0; s_y = 0; s_rev = 0; s_air = 0; s_walk = 0; s_wf = 0;
  endtask

  // One rising edge of the model, using the inputs currently driven
  task automatic model_edge();
    int mx, my, rv, air, wlk, wf, left, hit, p, c, r, a;
`ifdef MARIO_SHADOW_EN
    mx = s_x; my = s_y; rv = s_rev; air = s_air; wlk = s_walk; wf = s_wf;
`else
    mx = int'(MarioX); my = int'(MarioY); rv = int'(reverse);
    air = int'(in_air); wlk = int'(walking); wf = int'(walking_frame);
`endif
    left = mx - 16;
    hit = (int'(DrawX) < 640) && (int'(DrawY) < 480) &&
          (int'(DrawX) >= left) && (int'(DrawX) < mx) &&
          (int'(DrawY) >= my) && (int'(DrawY) < my + 16);
    if (air != 0)      p = 4;
    else if (wlk != 0) p = 1 + ((wf / 8) < 2 ? (wf / 8) : 2);
    else               p = 0;
    c = int'(DrawX) - left;
    if (rv != 0) c = 15 - c;
    r = int'(DrawY) - my;
    a = p * 256 + r * 16 + c;
    // output stage sees the hit from two edges back
    m_on  = (m_h2 != 0 && rom_fn(m_a2) != 0) ? 1 : 0;
    m_idx = (m_on != 0) ? rom_fn(m_a2) : 0;
    m_h2 = m_h1; m_a2 = m_a1;
    m_h1 = hit;  m_a1 = a;
    if (hit != 0) begin
      m_addr = a;
      m_pose = p;
    end
    if (m_vs_prev == 1 && vs == 1'b0) begin
      s_x = int'(MarioX); s_y = int'(MarioY); s_rev = int'(reverse);
      s_air = int'(in_air); s_walk = int'(walking); s_wf = int'(walking_frame);
    end
    m_vs_prev = int'(vs);
  endtask

  // Inputs are set at a falling edge; advance one clock and compare
  task automatic tick();
    model_edge();
    @(negedge frame_clk);
    check("rom_addr",  int'(rom_addr),  m_addr);
    check("pose",      int'(pose),      m_pose);
    check("mario_on",  int'(mario_on),  m_on);
    check("mario_idx", int'(mario_idx), m_idx);
  endtask

  // vs high then low: loads the shadow copies when that build is enabled
  task automatic load_frame();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
    vs = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; vs = 1'b1;
    DrawX = '0; DrawY = '0; MarioX = '0; MarioY = '0;
    reverse = 1'b0; in_air = 1'b0; walking = 1'b0; walking_frame = '0;
    model_reset();
    @(negedge frame_clk);
    @(negedge frame_clk);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_on",   int'(mario_on), 0);
    check("rst_idx",  int'(mario_idx), 0);
    check("rst_pose", int'(pose), 0);
    Reset = 1'b0;

    // Idle Mario, top-left sprite pixel
    MarioX = 10'd160; MarioY = 10'd399;
    DrawX = 10'd100; DrawY = 10'd399;
    load_frame();
    DrawX = 10'd144;
    tick(); check("idle_addr", int'(rom_addr), 0);
    tick(); tick();
    check("idle_on",  int'(mario_on), 1);
    check("idle_idx", int'(mario_idx), rom_fn(0));

    // Mirrored sprite
    reverse = 1'b1; DrawX = 10'd100; load_frame();
    DrawX = 10'd144; tick(); check("rev_144", int'(rom_addr), 15);
    DrawX = 10'd159; tick(); check("rev_159", int'(rom_addr), 0);
    DrawX = 10'd160; tick(); tick(); tick();
    check("rev_160_off", int'(mario_on), 0);

    // Left-edge clipping, no wrap to the right edge
    reverse = 1'b0; MarioX = 10'd5; DrawX = 10'd300; load_frame();
    DrawX = 10'd0; tick(); check("clip_addr", int'(rom_addr), 11);
    DrawX = 10'd635; tick(); tick(); tick();
    check("nowrap_on",   int'(mario_on), 0);
    check("nowrap_hold", int'(rom_addr), 11);

    // Pose priority and walk saturation
    MarioX = 10'd160; DrawX = 10'd150;
    in_air = 1'b1; walking = 1'b1; load_frame(); tick();
    check("pose_jump", int'(pose), 4);
    in_air = 1'b0; walking_frame = 5'd31; load_frame(); tick();
    check("pose_w31", int'(pose), 3);
    walking_frame = 5'd8; load_frame(); tick();
    check("pose_w8", int'(pose), 2);

`ifdef MARIO_SHADOW_EN
    // Mid-frame move is ignored until the next vs falling edge
    walking = 1'b0; walking_frame = '0; DrawX = 10'd150; load_frame();
    MarioX = 10'd200; tick();
    check("shadow_old", int'(rom_addr), 6);
    load_frame();
    DrawX = 10'd186; tick();
    check("shadow_new", int'(rom_addr), 2);
`endif

    // Asynchronous reset while Mario is being drawn
    walking = 1'b0; walking_frame = '0; MarioX = 10'd160; DrawX = 10'd144;
    load_frame(); tick(); tick(); tick();
    check("pre_rst_on", int'(mario_on), 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_on",   int'(mario_on), 0);
    check("arst_idx",  int'(mario_idx), 0);
    check("arst_addr", int'(rom_addr), 0);
    check("arst_pose", int'(pose), 0);
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
    tick(); tick();
    check("post_rst_on", int'(mario_on), 0);

    // Randomized traffic biased toward the sprite
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        MarioX = 10'($urandom_range(0, 660));
        MarioY = 10'($urandom_range(0, 490));
        reverse = 1'($urandom); in_air = 1'($urandom_range(0, 3) == 0);
        walking = 1'($urandom); walking_frame = 5'($urandom);
      end
      vs = ($urandom_range(0, 7) != 0);
      DrawX = 10'(int'(MarioX) - 18 + int'($urandom_range(0, 21)));
      DrawY = 10'(int'(MarioY) - 2 + int'($urandom_range(0, 19)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
